ram_burst_reader: RTL

- Read-side master for the single-write, dual-read asynchronous RAM.
- Drives the RAM's second read address, captures its combinational read data, and streams a burst of words out on a valid/ready interface.
- Sits between RAM read port B and downstream consumers such as UART TX or a video/line-buffer drain.
- A burst is defined by a start address and a word count; the address wraps modulo RAM depth.

---
 rtl/ram_burst_reader.sv | 100 ++++++++++
 1 files changed

// File: rtl/ram_burst_reader.sv
// Burst read master for RAM read port B: walks a wrapping address range and
// streams each captured word out over a valid/ready interface.
module ram_burst_reader #(
   parameter int unsigned ADDR_WIDTH = 6,
   parameter int unsigned DATA_WIDTH = 8
) (
   input  logic                  clk,
   input  logic                  reset_n,
   input  logic                  start,
   input  logic [ADDR_WIDTH-1:0] base_addr,
   input  logic [ADDR_WIDTH:0]   len,
   output logic [ADDR_WIDTH-1:0] rd_addr,
   input  logic [DATA_WIDTH-1:0] rd_data,
   output logic [DATA_WIDTH-1:0] m_data,
   output logic                  m_valid,
   input  logic                  m_ready,
   output logic                  busy,
   output logic                  done
);

   typedef enum logic [1:0] {StIdle, StRun, StFlush} state_e;

   state_e                state_q, state_d;
   logic [ADDR_WIDTH-1:0] rd_addr_q, rd_addr_d;
   logic [ADDR_WIDTH:0]   remaining_q, remaining_d;
   logic [DATA_WIDTH-1:0] m_data_q, m_data_d;
   logic                  m_valid_q, m_valid_d;
   logic                  done_q, done_d;
   logic                  load;

   // Output register is empty or being drained this cycle
   assign load = (state_q == StRun) && (!m_valid_q || m_ready);

   always_comb begin
      state_d     = state_q;
      rd_addr_d   = rd_addr_q;
      remaining_d = remaining_q;
      m_data_d    = m_data_q;
      m_valid_d   = m_valid_q;
      done_d      = 1'b0;
      unique case (state_q)
         StIdle: begin
            if (start) begin
               if (|len) begin
                  rd_addr_d   = base_addr;
                  remaining_d = len;
                  state_d     = StRun;
               end else begin
                  done_d = 1'b1;
               end
            end
         end
         StRun: begin
            if (load) begin
               m_data_d    = rd_data;
               m_valid_d   = 1'b1;
               rd_addr_d   = rd_addr_q + ADDR_WIDTH'(1);
               remaining_d = remaining_q - (ADDR_WIDTH + 1)'(1);
               if (remaining_q == (ADDR_WIDTH + 1)'(1)) begin
                  state_d = StFlush;
               end
            end
         end
         StFlush: begin
            // Last word is held in m_data until the consumer takes it
            if (m_ready) begin
               m_valid_d = 1'b0;
               done_d    = 1'b1;
               state_d   = StIdle;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q     <= StIdle;
         rd_addr_q   <= '0;
         remaining_q <= '0;
         m_data_q    <= '0;
         m_valid_q   <= 1'b0;
         done_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         rd_addr_q   <= rd_addr_d;
         remaining_q <= remaining_d;
         m_data_q    <= m_data_d;
         m_valid_q   <= m_valid_d;
         done_q      <= done_d;
      end
   end

   assign rd_addr = rd_addr_q;
   assign m_data  = m_data_q;
   assign m_valid = m_valid_q;
   assign done    = done_q;
   assign busy    = (state_q != StIdle);

endmodule
